memory_access: RTL

// - MEM pipeline stage of the RISC-V core; consumes the EX-stage register outputs and drives the data-memory bus master.
// - Issues loads/stores with a req/ack handshake; formats load data (sign/zero extension); stalls upstream while waiting.
// - Registers the writeback result, rd and write_reg for WB and for the EX forwarding unit.

---
 rtl/memory_access.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/memory_access.sv
// memory_access: MEM stage of the RISC-V core.
// Drives the data-memory bus with a req/ack handshake, formats load data,
// stalls upstream while an access is outstanding and registers the WB result.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (trap misaligned half/word
// accesses instead of silently aligning them).
module memory_access #(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result_from_execution,
  input  logic [31:0] rs2_data_from_execution,
  input  logic [2:0]  funct3_from_execution,
  input  logic [4:0]  rd_from_execution,
  input  logic        write_reg_from_execution,
  input  logic        select_from_execution,
  input  logic        read_from_execution,
  input  logic        write_from_execution,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] result_from_memory,
  output logic [4:0]  rd_from_memory,
  output logic        write_reg_from_memory,
  output logic        stall_from_memory,
  output logic        bus_error_from_memory,
  output logic        misaligned_from_memory
);

  localparam int CW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] timeout_cnt;

  // Captured operation, needed when the ack arrives.
  logic [2:0]    op_funct3;
  logic [1:0]    op_off;
  logic [31:0]   op_addr;
  logic [4:0]    op_rd;
  logic          op_write_reg;
  logic          op_select;
  logic          op_load;

  logic          mem_op;
  logic          misaligned_in;
  logic          ack_done;
  logic          timeout_hit;
  logic          accept;
  logic          start;

  // Byte enables for the access size; halves are placed by addr[1].
  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   lane_be = 4'b0001 << off;
      2'b01:   lane_be = off[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated over every lane so the slave just applies dmem_be.
  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   lane_wdata = {4{d[7:0]}};
      2'b01:   lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

  // Pick the addressed byte/half out of the read word and extend it.
  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'b00:   b = d[7:0];
      2'b01:   b = d[15:8];
      2'b10:   b = d[23:16];
      default: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  load_fmt = {{24{b[7]}}, b};
      3'b100:  load_fmt = {24'h000000, b};
      3'b001:  load_fmt = {{16{h[15]}}, h};
      3'b101:  load_fmt = {16'h0000, h};
      default: load_fmt = d;
    endcase
  endfunction

  assign mem_op = read_from_execution | write_from_execution;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned_in = mem_op &
                         (((funct3_from_execution[1:0] == 2'b01) & result_from_execution[0]) |
                          (funct3_from_execution[1] & (result_from_execution[1:0] != 2'b00)));
`else
  assign misaligned_in = 1'b0;
`endif

  assign ack_done          = (state == REQ) & dmem_ack;
  assign timeout_hit       = (state == REQ) & (timeout_cnt == TIMEOUT_LAST);
  assign stall_from_memory = (state == REQ) & ~dmem_ack & ~timeout_hit;
  assign accept            = ~stall_from_memory;
  assign start             = accept & mem_op & ~misaligned_in;

  // Next-state logic: ack beats timeout; a new op at the ack edge chains.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = REQ;
        else       state_next = IDLE;
      end
      REQ: begin
        if (ack_done)         state_next = start ? REQ : IDLE;
        else if (timeout_hit) state_next = IDLE;
        else                  state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, bus master fields, captured op and writeback outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      timeout_cnt           <= '0;
      dmem_req              <= 1'b0;
      dmem_we               <= 1'b0;
      dmem_addr             <= 32'h00000000;
      dmem_wdata            <= 32'h00000000;
      dmem_be               <= 4'b0000;
      op_funct3             <= 3'b000;
      op_off                <= 2'b00;
      op_addr               <= 32'h00000000;
      op_rd                 <= 5'd0;
      op_write_reg          <= 1'b0;
      op_select             <= 1'b0;
      op_load               <= 1'b0;
      result_from_memory    <= 32'h00000000;
      rd_from_memory        <= 5'd0;
      write_reg_from_memory <= 1'b0;
      bus_error_from_memory <= 1'b0;
    end else begin
      state                 <= state_next;
      dmem_req              <= (state_next == REQ);
      bus_error_from_memory <= 1'b0;

      if (stall_from_memory) timeout_cnt <= timeout_cnt + CW'(1);
      else                   timeout_cnt <= '0;

      if (start) begin
        dmem_we      <= write_from_execution & ~read_from_execution;
        dmem_addr    <= {result_from_execution[31:2], 2'b00};
        dmem_wdata   <= lane_wdata(funct3_from_execution, rs2_data_from_execution);
        dmem_be      <= lane_be(funct3_from_execution, result_from_execution[1:0]);
        op_funct3    <= funct3_from_execution;
        op_off       <= result_from_execution[1:0];
        op_addr      <= result_from_execution;
        op_rd        <= rd_from_execution;
        op_write_reg <= write_reg_from_execution;
        op_select    <= select_from_execution;
        op_load      <= read_from_execution;
      end

      if (state == REQ) begin
        if (ack_done) begin
          rd_from_memory <= op_rd;
          if (op_load) begin
            result_from_memory    <= op_select ? load_fmt(op_funct3, op_off, dmem_rdata) : op_addr;
            write_reg_from_memory <= op_write_reg;
          end else begin
            write_reg_from_memory <= 1'b0;
          end
        end else if (timeout_hit) begin
          write_reg_from_memory <= 1'b0;
          bus_error_from_memory <= 1'b1;
        end else begin
          write_reg_from_memory <= 1'b0;
        end
      end else begin
        result_from_memory    <= result_from_execution;
        rd_from_memory        <= rd_from_execution;
        write_reg_from_memory <= mem_op ? 1'b0 : write_reg_from_execution;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Misaligned pulse one cycle after the offending op is sampled.
  always_ff @(posedge clk) begin
    if (rst) misaligned_from_memory <= 1'b0;
    else     misaligned_from_memory <= accept & misaligned_in;
  end
`else
  assign misaligned_from_memory = 1'b0;
`endif

endmodule
